writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 26 ++
 rtl/writeback_unit_if.sv | 36 +++
 rtl/writeback_unit_load_align.sv | 48 ++++
 rtl/writeback_unit.sv | 93 +++++++++
 tb/tb_writeback_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared core types: load funct3 encodings, holding entries, arbitration default
package writeback_unit_pkg;

  localparam int STARVE_MAX_DEFAULT = 3;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_entry_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] data;
  } ld_entry_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU/load result channels and register-file write port
interface writeback_unit_if;

  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_ptr_i;
  logic [31:0] alu_data_i;

  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_ptr_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_addr_lo_i;
  logic [31:0] ld_data_i;

  logic        reg_write_en_o;
  logic [4:0]  rd_ptr_o;
  logic [31:0] rd_o;
  logic        ld_err_o;
  logic        busy_o;

  modport slave (
    input  alu_valid_i, alu_rd_ptr_i, alu_data_i,
    input  ld_valid_i, ld_rd_ptr_i, ld_funct3_i, ld_addr_lo_i, ld_data_i,
    output alu_ready_o, ld_ready_o,
    output reg_write_en_o, rd_ptr_o, rd_o, ld_err_o, busy_o
  );

  modport master (
    output alu_valid_i, alu_rd_ptr_i, alu_data_i,
    output ld_valid_i, ld_rd_ptr_i, ld_funct3_i, ld_addr_lo_i, ld_data_i,
    input  alu_ready_o, ld_ready_o,
    input  reg_write_en_o, rd_ptr_o, rd_o, ld_err_o, busy_o
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load byte/half extraction, sign/zero extension and legality check
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = data_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = data_i[15:8];
      2'd2:    byte_v = data_i[23:16];
      2'd3:    byte_v = data_i[31:24];
      default: byte_v = data_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {24'd0, byte_v};
      F3_LH: begin
        data_o = {{16{half_v[15]}}, half_v};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {16'd0, half_v};
        err_o  = addr_lo_i[0];
      end
      F3_LW: begin
        data_o = data_i;
        err_o  = (addr_lo_i != 2'd0);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - two-entry writeback arbiter: load-first with bounded ALU starvation
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  writeback_unit_if.slave wb
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  alu_entry_t    alu_q;
  ld_entry_t     ld_q;
  logic          alu_full, ld_full;
  logic [CW-1:0] starve_cnt;
  logic          grant_ld, grant_alu;
  logic          alu_take, ld_take;
  logic          alu_full_n, ld_full_n;
  logic [31:0]   ld_data;
  logic          ld_err;

  load_align u_load_align (
    .funct3_i  (ld_q.funct3),
    .addr_lo_i (ld_q.addr_lo),
    .data_i    (ld_q.data),
    .data_o    (ld_data),
    .err_o     (ld_err)
  );

  // A waiting ALU result overrides load priority once it has lost STARVE_MAX times in a row.
  always_comb begin
    grant_ld       = ld_full && !(alu_full && (starve_cnt >= CNT_MAX));
    grant_alu      = alu_full && !grant_ld;
    wb.alu_ready_o = !rst_i && (!alu_full || grant_alu);
    wb.ld_ready_o  = !rst_i && (!ld_full || grant_ld);
    alu_take       = wb.alu_valid_i && wb.alu_ready_o;
    ld_take        = wb.ld_valid_i && wb.ld_ready_o;
    alu_full_n     = alu_take || (alu_full && !grant_alu);
    ld_full_n      = ld_take || (ld_full && !grant_ld);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_full          <= 1'b0;
      ld_full           <= 1'b0;
      alu_q             <= '0;
      ld_q              <= '0;
      starve_cnt        <= '0;
      wb.reg_write_en_o <= 1'b0;
      wb.rd_ptr_o       <= '0;
      wb.rd_o           <= '0;
      wb.ld_err_o       <= 1'b0;
      wb.busy_o         <= 1'b0;
    end else begin
      alu_full  <= alu_full_n;
      ld_full   <= ld_full_n;
      wb.busy_o <= alu_full_n || ld_full_n;
      if (alu_take) begin
        alu_q <= '{rd: wb.alu_rd_ptr_i, data: wb.alu_data_i};
      end
      if (ld_take) begin
        ld_q <= '{rd: wb.ld_rd_ptr_i, funct3: wb.ld_funct3_i,
                  addr_lo: wb.ld_addr_lo_i, data: wb.ld_data_i};
      end

      if (grant_alu || !alu_full) begin
        starve_cnt <= '0;
      end else if (grant_ld && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      // rd_ptr_o/rd_o only move on a real write; x0 targets and faulting loads leave them intact.
      wb.reg_write_en_o <= 1'b0;
      wb.ld_err_o       <= 1'b0;
      if (grant_ld) begin
        wb.ld_err_o <= ld_err;
        if (!ld_err && (ld_q.rd != 5'd0)) begin
          wb.reg_write_en_o <= 1'b1;
          wb.rd_ptr_o       <= ld_q.rd;
          wb.rd_o           <= ld_data;
        end
      end else if (grant_alu && (alu_q.rd != 5'd0)) begin
        wb.reg_write_en_o <= 1'b1;
        wb.rd_ptr_o       <= alu_q.rd;
        wb.rd_o           <= alu_q.data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard bench for writeback_unit
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  typedef struct packed {
    logic        err;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if wb();

  writeback_unit #(.STARVE_MAX(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (wb)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t wr(logic [4:0] rd, logic [31:0] data);
    return '{err: 1'b0, rd: rd, data: data};
  endfunction

  function automatic exp_t fault();
    return '{err: 1'b1, rd: 5'd0, data: 32'd0};
  endfunction

  // Every write or error pulse must match the oldest outstanding expectation.
  exp_t        mon_e;
  logic [38:0] mon_obs, mon_exp;
  always @(negedge clk) begin
    if (wb.reg_write_en_o || wb.ld_err_o) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_write", {wb.reg_write_en_o, wb.ld_err_o}, 2'b00);
      end else begin
        mon_e   = sb.pop_front();
        mon_obs = {wb.reg_write_en_o, wb.ld_err_o,
                   wb.ld_err_o ? 5'd0 : wb.rd_ptr_o, wb.ld_err_o ? 32'd0 : wb.rd_o};
        mon_exp = {~mon_e.err, mon_e.err, mon_e.rd, mon_e.data};
        check_eq("sb_write", mon_obs, mon_exp);
      end
    end
  end

  task automatic alu_push(logic [4:0] rd, logic [31:0] data);
    int n = 0;
    @(negedge clk);
    wb.alu_valid_i  = 1'b1;
    wb.alu_rd_ptr_i = rd;
    wb.alu_data_i   = data;
    forever begin
      #1;
      if (wb.alu_ready_o) break;
      n++;
      if (n > 50) begin
        check_eq("alu_push_timeout", n, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic ld_push(logic [4:0] rd, logic [2:0] f3, logic [1:0] lo, logic [31:0] data);
    int n = 0;
    @(negedge clk);
    wb.ld_valid_i   = 1'b1;
    wb.ld_rd_ptr_i  = rd;
    wb.ld_funct3_i  = f3;
    wb.ld_addr_lo_i = lo;
    wb.ld_data_i    = data;
    forever begin
      #1;
      if (wb.ld_ready_o) break;
      n++;
      if (n > 50) begin
        check_eq("ld_push_timeout", n, 0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic alu_idle();
    @(negedge clk);
    wb.alu_valid_i = 1'b0;
  endtask

  task automatic ld_idle();
    @(negedge clk);
    wb.ld_valid_i = 1'b0;
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wb.alu_valid_i = 1'b0; wb.alu_rd_ptr_i = '0; wb.alu_data_i = '0;
    wb.ld_valid_i = 1'b0; wb.ld_rd_ptr_i = '0; wb.ld_funct3_i = '0;
    wb.ld_addr_lo_i = '0; wb.ld_data_i = '0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_we", wb.reg_write_en_o, 1'b0);
    check_eq("rst_rd_ptr", wb.rd_ptr_o, 5'd0);
    check_eq("rst_rd", wb.rd_o, 32'd0);
    check_eq("rst_err", wb.ld_err_o, 1'b0);
    check_eq("rst_busy", wb.busy_o, 1'b0);
    check_eq("rst_readies", {wb.alu_ready_o, wb.ld_ready_o}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Two-edge latency, one-cycle write pulse.
    sb.push_back(wr(5'd5, 32'h1234));
    alu_push(5'd5, 32'h1234);
    alu_idle();
    #1;
    check_eq("lat_edge_n", wb.reg_write_en_o, 1'b0);
    @(negedge clk); #1;
    check_eq("lat_write", {wb.reg_write_en_o, wb.rd_ptr_o, wb.rd_o}, {1'b1, 5'd5, 32'h1234});
    @(negedge clk); #1;
    check_eq("lat_pulse_end", wb.reg_write_en_o, 1'b0);

    // Load extraction and extension.
    sb.push_back(wr(5'd7, 32'hFFFF_FF80));
    ld_push(5'd7, F3_LB, 2'd2, 32'h0080_0000);
    sb.push_back(wr(5'd8, 32'h0000_8001));
    ld_push(5'd8, F3_LHU, 2'd2, 32'h8001_0000);
    sb.push_back(wr(5'd11, 32'hFFFF_8765));
    ld_push(5'd11, F3_LH, 2'd0, 32'h1234_8765);
    sb.push_back(wr(5'd12, 32'h0000_00AB));
    ld_push(5'd12, F3_LBU, 2'd3, 32'hAB00_0000);
    sb.push_back(wr(5'd13, 32'hCAFE_F00D));
    ld_push(5'd13, F3_LW, 2'd0, 32'hCAFE_F00D);
    ld_idle();
    wait_drain("drain_align");

    // Misaligned LW: error pulse, no write, channel free again.
    sb.push_back(fault());
    ld_push(5'd3, F3_LW, 2'd1, 32'hDEAD_BEEF);
    ld_idle();
    @(negedge clk); #1;
    check_eq("err_pulse", {wb.ld_err_o, wb.reg_write_en_o, wb.ld_ready_o}, 3'b101);
    @(negedge clk); #1;
    check_eq("err_pulse_end", wb.ld_err_o, 1'b0);
    sb.push_back(fault());
    ld_push(5'd4, 3'b011, 2'd0, 32'h1);
    sb.push_back(fault());
    ld_push(5'd4, F3_LHU, 2'd1, 32'h2);
    ld_idle();
    wait_drain("drain_err");

    // x0 target is consumed silently; the next entry still flows.
    alu_push(5'd0, 32'h5555);
    sb.push_back(wr(5'd1, 32'h77));
    alu_push(5'd1, 32'h77);
    alu_idle();
    wait_drain("drain_rd0");

    // Same rd on both channels in one cycle: load then ALU, ALU wins.
    sb.push_back(wr(5'd9, 32'h1111_1111));
    sb.push_back(wr(5'd9, 32'h2222_2222));
    fork
      begin ld_push(5'd9, F3_LW, 2'd0, 32'h1111_1111); ld_idle(); end
      begin alu_push(5'd9, 32'h2222_2222); alu_idle(); end
    join
    wait_drain("drain_same_rd");
    check_eq("same_rd_final", {wb.rd_ptr_o, wb.rd_o}, {5'd9, 32'h2222_2222});

    // Sustained traffic on both channels: L,L,L,A repeating.
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) sb.push_back(wr(5'(10 + 3 * g + k), 32'h1000_0000 + 32'(3 * g + k)));
      sb.push_back(wr(5'(20 + g), 32'hA000_0000 + 32'(g)));
    end
    fork
      begin
        for (int i = 0; i < 9; i++) ld_push(5'(10 + i), F3_LW, 2'd0, 32'h1000_0000 + 32'(i));
        ld_idle();
      end
      begin
        for (int j = 0; j < 3; j++) alu_push(5'(20 + j), 32'hA000_0000 + 32'(j));
        alu_idle();
      end
    join
    wait_drain("drain_starve");

    // Reset with both holdings full discards them.
    fork
      alu_push(5'd2, 32'hAAAA);
      ld_push(5'd2, F3_LW, 2'd0, 32'hBBBB);
    join
    @(negedge clk);
    rst = 1'b1;
    wb.alu_valid_i = 1'b0;
    wb.ld_valid_i  = 1'b0;
    #1;
    check_eq("busy_full", wb.busy_o, 1'b1);
    @(negedge clk); #1;
    check_eq("rst_mid_state", {wb.alu_ready_o, wb.ld_ready_o, wb.busy_o, wb.reg_write_en_o}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check_eq("post_rst_ready", {wb.alu_ready_o, wb.ld_ready_o, wb.busy_o}, 3'b110);
    repeat (6) @(negedge clk);
    check_eq("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
